// File: rtl/branch_pkg.sv
// Shared definitions for the RV32I branch resolver: operand width and the
// conditional-branch funct3 encodings, plus a helper that flags reserved
// funct3 values inside the BRANCH opcode space.
package branch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } branch_funct3_e;

  // 010 and 011 are reserved in the BRANCH major opcode.
  function automatic logic is_reserved_funct3(input logic [2:0] f3);
    return (f3[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/branch_compare.sv
// Purely combinational operand comparator for the branch resolver.
// Produces equality, signed less-than and unsigned less-than over the full
// XLEN-bit operands; the top level picks one of these per funct3.
module branch_compare
  import branch_pkg::*;
(
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_eq,
  output logic            o_lt_signed,
  output logic            o_lt_unsigned
);

  logic w_sign_differs;
  logic w_mag_lt;

  // Signed less-than is derived from the unsigned compare: when the sign bits
  // differ, the operand with its sign bit set is the smaller one.
  always_comb begin
    w_mag_lt       = (i_a < i_b);
    w_sign_differs = i_a[XLEN-1] ^ i_b[XLEN-1];
    o_eq           = (i_a == i_b);
    o_lt_unsigned  = w_mag_lt;
    o_lt_signed    = w_sign_differs ? i_a[XLEN-1] : w_mag_lt;
  end

endmodule

// File: rtl/rv_branch_unit.sv
// RV32I conditional-branch resolver for the execute stage.
// branch_taken / illegal_funct3 are combinational so PC-select can redirect
// fetch in the same cycle; branch_taken_q is a registered copy.
// Optional statistics counters are compiled in with BRANCH_UNIT_STATS_EN.
module rv_branch_unit
  import branch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [2:0]      funct3,
  input  logic            branch,
  output logic            branch_taken,
  output logic            illegal_funct3,
  output logic            branch_taken_q
`ifdef BRANCH_UNIT_STATS_EN
  ,
  output logic [XLEN-1:0] branch_count,
  output logic [XLEN-1:0] taken_count
`endif
);

  logic w_eq;
  logic w_lt_signed;
  logic w_lt_unsigned;
  logic w_cond;
  logic r_branch_taken_q;

  branch_compare u_compare (
    .i_a           (operand_a),
    .i_b           (operand_b),
    .o_eq          (w_eq),
    .o_lt_signed   (w_lt_signed),
    .o_lt_unsigned (w_lt_unsigned)
  );

  // Select the comparator flag named by funct3; reserved encodings never take.
  always_comb begin
    w_cond = 1'b0;
    case (funct3)
      BEQ:     w_cond = w_eq;
      BNE:     w_cond = ~w_eq;
      BLT:     w_cond = w_lt_signed;
      BGE:     w_cond = ~w_lt_signed;
      BLTU:    w_cond = w_lt_unsigned;
      BGEU:    w_cond = ~w_lt_unsigned;
      default: w_cond = 1'b0;
    endcase
  end

  // Gate with branch using a ternary so an unknown funct3 cannot leak through
  // when no branch is in the stage.
  always_comb begin
    branch_taken   = branch ? w_cond : 1'b0;
    illegal_funct3 = branch ? is_reserved_funct3(funct3) : 1'b0;
  end

  // Registered copy of the decision, sampled every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_taken_q <= 1'b0;
    end else begin
      r_branch_taken_q <= branch_taken;
    end
  end

  assign branch_taken_q = r_branch_taken_q;

`ifdef BRANCH_UNIT_STATS_EN
  logic [XLEN-1:0] r_branch_count;
  logic [XLEN-1:0] r_taken_count;

  // Evaluated/taken counters; free-running wrap at 2^XLEN. Reserved
  // encodings count as evaluated since branch_taken is already low for them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_count <= '0;
      r_taken_count  <= '0;
    end else if (branch) begin
      r_branch_count <= r_branch_count + 1'b1;
      if (branch_taken) begin
        r_taken_count <= r_taken_count + 1'b1;
      end
    end
  end

  assign branch_count = r_branch_count;
  assign taken_count  = r_taken_count;
`endif

endmodule

// File: tb/tb_rv_branch_unit.sv
// Scoreboard bench for rv_branch_unit: stimulus pushes expected responses,
// a monitor on the falling edge pops and compares them.
module tb_rv_branch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [2:0]  funct3;
  logic        branch;
  logic        branch_taken;
  logic        illegal_funct3;
  logic        branch_taken_q;
`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0] branch_count;
  logic [31:0] taken_count;
`endif

  rv_branch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .funct3         (funct3),
    .branch         (branch),
    .branch_taken   (branch_taken),
    .illegal_funct3 (illegal_funct3),
    .branch_taken_q (branch_taken_q)
`ifdef BRANCH_UNIT_STATS_EN
    ,
    .branch_count   (branch_count),
    .taken_count    (taken_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic taken;
    logic illegal;
  } comb_exp_t;

  comb_exp_t q_comb[$];
  logic      q_reg[$];
  logic      pend_reg = 1'b0;

  longint unsigned mdl_branch_cnt = 0;
  longint unsigned mdl_taken_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model written directly from the branch rules using 64-bit
  // integer arithmetic.
  function automatic logic ref_taken(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] f3, input logic br);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (!br) return 1'b0;
    case (f3)
      3'd0: return ua == ub;
      3'd1: return ua != ub;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return ua < ub;
      3'd7: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [2:0] f3, input logic br);
    return br && (f3 == 3'd2 || f3 == 3'd3);
  endfunction

  // Monitor: each falling edge checks the combinational outputs for the
  // current vector, and the registered output for the previous one.
  initial begin
    comb_exp_t e;
    logic      r;
    forever begin
      @(negedge clk);
      if (pend_reg) begin
        r = q_reg.pop_front();
        check("taken_q", {31'd0, branch_taken_q}, {31'd0, r});
      end
      if (q_comb.size() > 0) begin
        e = q_comb.pop_front();
        check("taken", {31'd0, branch_taken}, {31'd0, e.taken});
        check("illegal", {31'd0, illegal_funct3}, {31'd0, e.illegal});
        pend_reg = 1'b1;
      end else begin
        pend_reg = 1'b0;
      end
    end
  end

  // Apply one vector for exactly one rising edge and queue its expectations.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                       input logic br, input logic exp_t, input logic exp_i);
    comb_exp_t e;
    @(posedge clk);
    #2;
    operand_a = a;
    operand_b = b;
    funct3    = f3;
    branch    = br;
    e.taken   = exp_t;
    e.illegal = exp_i;
    q_comb.push_back(e);
    q_reg.push_back(exp_t);
    if (br) begin
      mdl_branch_cnt = (mdl_branch_cnt + 1) & 64'hFFFF_FFFF;
      if (exp_t) mdl_taken_cnt = (mdl_taken_cnt + 1) & 64'hFFFF_FFFF;
    end
  endtask

  // Retire the last vector (branch dropped after its edge) and wait, bounded,
  // for the monitor to consume everything.
  task automatic drain(input string name);
    @(posedge clk);
    #2;
    branch = 1'b0;
    for (int i = 0; i < 10 && (q_comb.size() > 0 || q_reg.size() > 0 || pend_reg); i++)
      @(negedge clk);
    #1;
    n_cmp++;
    if (q_comb.size() > 0 || q_reg.size() > 0) begin
      n_err++;
      $display("FAIL drain_%s: %0d/%0d entries left, expected 0", name, q_comb.size(), q_reg.size());
      q_comb.delete();
      q_reg.delete();
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 16));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic        br;
    logic        t;
    logic        il;
  } vec_t;

  vec_t dir[18] = '{
    '{32'd0,          32'd0,          3'b000, 1'b1, 1'b1, 1'b0},
    '{32'd5,          32'd5,          3'b000, 1'b1, 1'b1, 1'b0},
    '{32'd5,          32'd10,         3'b000, 1'b1, 1'b0, 1'b0},
    '{32'd5,          32'd10,         3'b001, 1'b1, 1'b1, 1'b0},
    '{32'd5,          32'd5,          3'b001, 1'b1, 1'b0, 1'b0},
    '{32'd5,          32'd10,         3'b100, 1'b1, 1'b1, 1'b0},
    '{32'hFFFF_FFF6,  32'hFFFF_FFFB,  3'b100, 1'b1, 1'b1, 1'b0},
    '{32'd10,         32'd5,          3'b100, 1'b1, 1'b0, 1'b0},
    '{32'd10,         32'd5,          3'b101, 1'b1, 1'b1, 1'b0},
    '{32'd5,          32'd5,          3'b101, 1'b1, 1'b1, 1'b0},
    '{32'd5,          32'd10,         3'b101, 1'b1, 1'b0, 1'b0},
    '{32'd10,         32'hFFFF_FFFF,  3'b110, 1'b1, 1'b1, 1'b0},
    '{32'd10,         32'd5,          3'b110, 1'b1, 1'b0, 1'b0},
    '{32'hFFFF_FFFF,  32'd10,         3'b111, 1'b1, 1'b1, 1'b0},
    '{32'd5,          32'd10,         3'b111, 1'b1, 1'b0, 1'b0},
    '{32'd5,          32'd5,          3'b000, 1'b0, 1'b0, 1'b0},
    '{32'd5,          32'd5,          3'b010, 1'b1, 1'b0, 1'b1},
    '{32'd7,          32'd7,          3'b011, 1'b1, 1'b0, 1'b1}
  };

  initial begin
    logic [31:0] a, b;
    logic [2:0]  f3;
    logic        br;

    rst_n     = 1'b0;
    operand_a = '0;
    operand_b = '0;
    funct3    = '0;
    branch    = 1'b0;

    // Reset held across several edges.
    #23;
    check("reset_taken_q", {31'd0, branch_taken_q}, 32'd0);
`ifdef BRANCH_UNIT_STATS_EN
    check("reset_branch_count", branch_count, 32'd0);
    check("reset_taken_count", taken_count, 32'd0);
`endif
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    foreach (dir[i])
      drive(dir[i].a, dir[i].b, dir[i].f3, dir[i].br, dir[i].t, dir[i].il);
    drain("directed");

    for (int i = 0; i < 400; i++) begin
      a  = pick_operand();
      b  = ($urandom_range(0, 3) == 0) ? a : pick_operand();
      f3 = 3'($urandom_range(0, 7));
      br = ($urandom_range(0, 4) != 0);
      drive(a, b, f3, br, ref_taken(a, b, f3, br), ref_illegal(f3, br));
    end
    drain("random");
`ifdef BRANCH_UNIT_STATS_EN
    check("rand_branch_count", branch_count, 32'(mdl_branch_cnt));
    check("rand_taken_count", taken_count, 32'(mdl_taken_cnt));
`endif

    // Asynchronous reset between edges while the registered output is high.
    drive(32'd5, 32'd5, 3'b000, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("async_pre_q", {31'd0, branch_taken_q}, 32'd1);
    #1;
    rst_n = 1'b0;
    mdl_branch_cnt = 0;
    mdl_taken_cnt  = 0;
    #1;
    check("async_q", {31'd0, branch_taken_q}, 32'd0);
    check("comb_in_reset", {31'd0, branch_taken}, 32'd1);
`ifdef BRANCH_UNIT_STATS_EN
    check("async_branch_count", branch_count, 32'd0);
    check("async_taken_count", taken_count, 32'd0);
`endif
    @(posedge clk);
    #1;
    check("held_reset_q", {31'd0, branch_taken_q}, 32'd0);
    branch = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // First edge after release samples normally.
    drive(32'd0, 32'd0, 3'b000, 1'b1, 1'b1, 1'b0);
    drain("post_reset");

`ifdef BRANCH_UNIT_STATS_EN
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    mdl_branch_cnt = 0;
    mdl_taken_cnt  = 0;
    #1;
    check("stats_clr_branch", branch_count, 32'd0);
    check("stats_clr_taken", taken_count, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    drive(32'd5,         32'd5,  3'b000, 1'b1, 1'b1, 1'b0);
    drive(32'd5,         32'd5,  3'b001, 1'b1, 1'b0, 1'b0);
    drive(32'd5,         32'd10, 3'b100, 1'b1, 1'b1, 1'b0);
    drive(32'hFFFF_FFFF, 32'd10, 3'b111, 1'b1, 1'b1, 1'b0);
    drain("stats");
    check("stats_branch_count", branch_count, 32'd4);
    check("stats_taken_count", taken_count, 32'd3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("stats_rst_branch", branch_count, 32'd0);
    check("stats_rst_taken", taken_count, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rv_branch_unit.md
# rv_branch_unit

RV32I conditional-branch resolver for the execute stage of the 5-stage pipeline. It compares two 32-bit operands according to the branch `funct3` field and asserts `branch_taken` in the same cycle, so the PC-select logic can redirect fetch. A registered copy of the decision and an illegal-encoding flag are also provided. Optional branch statistics counters can be compiled in.

## Interface
- Parameters: none; data width is fixed at 32 (RV32I).
- `clk`  in  1  pipeline clock; used only by the registered outputs and counters.
- `rst_n`  in  1  asynchronous, active-low reset.
- `operand_a`  in  32  rs1 value (forwarded).
- `operand_b`  in  32  rs2 value (forwarded).
- `funct3`  in  3  branch condition encoding.
- `branch`  in  1  current instruction is a conditional branch.
- `branch_taken`  out  1  combinational branch decision.
- `illegal_funct3`  out  1  combinational; `branch` is high with funct3 = 010 or 011.
- `branch_taken_q`  out  1  `branch_taken` registered on the rising edge of `clk`.
- `branch_count`  out  32  number of branches evaluated; present only with `BRANCH_UNIT_STATS_EN`.
- `taken_count`  out  32  number of taken branches; present only with `BRANCH_UNIT_STATS_EN`.

## Operation
- `branch_taken` = `branch` AND cond(funct3).
- cond(funct3) per encoding:
  - 000 BEQ: a == b.
  - 001 BNE: a != b.
  - 100 BLT: signed a < b.
  - 101 BGE: signed a >= b.
  - 110 BLTU: unsigned a < b.
  - 111BGEU: unsigned a >= b.
- Comparisons are full 32-bit two's complement (signed) or magnitude (unsigned); there is no operand extension or truncation.
- funct3 = 010 or 011: cond = 0, so `branch_taken` = 0. `illegal_funct3` = `branch` for these encodings.
- `branch` = 0 forces `branch_taken` = 0 and `illegal_funct3` = 0, regardless of operands and funct3.
- No X-propagation from `funct3` when `branch` = 0: the output is a clean 0.

## Timing
- `branch_taken` and `illegal_funct3` are purely combinational: zero cycles of latency, valid within the same delta as the input change.
- `branch_taken_q` updates on every rising edge of `clk`; there is no enable and no handshake.
- `rst_n` low asynchronously clears `branch_taken_q` and both counters to 0.
- The combinational outputs are unaffected by reset.
- Reset asserted mid-operation clears the registered state immediately. The first edge after release samples normally.

## Configuration
- Macro `BRANCH_UNIT_STATS_EN`.
- Defined:
  - On each rising edge with `branch` = 1, `branch_count` increments by 1.
  - If `branch_taken` = 1 on that edge, `taken_count` also increments.
  - Illegal encodings count as evaluated but not taken.
  - Both counters wrap from 0xFFFFFFFF to 0 and reset to 0.
- Undefined: the counter ports and logic are absent, and all other behaviour is identical.

## Structure
- Shared package `branch_pkg`:
  - enum `branch_funct3_e` (BEQ=3'b000, BNE=3'b001, BLT=3'b100, BGE=3'b101, BLTU=3'b110, BGEU=3'b111).
  - constant `XLEN` = 32.
- One natural sub-module, `branch_compare`. It is purely combinational; it takes a, b and produces eq, lt_signed, lt_unsigned.
- The top-level module selects among these flags by funct3 and holds the registers and counters.

## Test plan
- BEQ/BNE:
  - a=0, b=0, f3=000 -> taken=1.
  - a=5, b=5, f3=000 -> 1.
  - a=5, b=10, f3=000 -> 0.
  - a=5, b=10, f3=001 -> 1.
  - a=5, b=5, f3=001 -> 0.
- BLT/BGE:
  - 5<10 -> 1.
  - 0xFFFFFFF6<0xFFFFFFFB -> 1.
  - 10<5 -> 0.
  - BGE 10,5 -> 1.
  - BGE 5,5 -> 1.
  - BGE 5,10 -> 0.
- BLTU/BGEU:
  - BLTU 10,0xFFFFFFFF -> 1.
  - BLTU 10,5 -> 0.
  - BGEU 0xFFFFFFFF,10 -> 1.
  - BGEU 5,10 -> 0.
- Disabled and illegal:
  - branch=0, a=b=5, f3=000 -> taken=0, illegal=0.
  - branch=1, f3=010 -> taken=0, illegal=1.
- Registered path:
  - Hold rst_n=0 -> branch_taken_q=0.
  - Release reset, apply a taken BEQ, one clk edge -> branch_taken_q=1.
  - Assert rst_n low asynchronously between edges -> branch_taken_q=0 immediately.
- Stats (with `BRANCH_UNIT_STATS_EN`):
  - Apply 4 clocked branches with 3 taken -> branch_count=4, taken_count=3.
  - Reset -> both counters = 0.
